// File: rtl/pmu_pkg.sv
// Shared definitions for the UART wake detector slice.
// State codes are plain logic constants so older netlists and probes keep their encodings.
// The configuration macro UART_WAKE_BYTE_MATCH_EN (used in uart_wake_detector) enables the DATA/STOP states.
package pmu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ARMED    = 3'd1;
    localparam state_t ST_LOW_QUAL = 3'd2;
    localparam state_t ST_DATA     = 3'd3;
    localparam state_t ST_STOP     = 3'd4;
    localparam state_t ST_HOLDOFF  = 3'd5;

    localparam int unsigned WAKE_CNT_W = 8;

    localparam int unsigned DEF_CLKS_PER_BIT   = 868;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 8680;

    // Bits needed by the shared down-counter. The first data-bit delay can reach
    // 1.5 bit times, so bit timing is sized from twice the bit period.
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit,
                                              input int unsigned holdoff_cycles);
        int unsigned longest;
        longest = (2 * clks_per_bit > holdoff_cycles) ? 2 * clks_per_bit : holdoff_cycles;
        return (longest < 2) ? 1 : $clog2(longest + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_CLKS_PER_BIT, DEF_HOLDOFF_CYCLES);

    // States in which the detector reports itself busy.
    function automatic logic is_busy(input state_t s);
        return (s == ST_LOW_QUAL) || (s == ST_DATA) || (s == ST_STOP) || (s == ST_HOLDOFF);
    endfunction

endpackage

// File: rtl/pmu_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL sets the value every stage takes during reset (1 for an idle-high UART line).
module pmu_sync
    import pmu_pkg::*;
#(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
)(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; the last stage is the synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_wake_detector.sv
// Always-on UART wake source: raises a one-cycle uart_wake pulse when, during sleep,
// the RX line shows a qualified start condition, then ignores the line for a holdoff window.
// Optional macro UART_WAKE_BYTE_MATCH_EN: additionally receive one 8N1 byte and wake
// only if it equals WAKE_BYTE with a valid stop bit.
module uart_wake_detector
    import pmu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned MIN_LOW_CYCLES = 434,
    parameter int unsigned HOLDOFF_CYCLES = 8680,
    parameter logic [7:0]  WAKE_BYTE      = 8'h55,
    parameter int unsigned SYNC_STAGES    = 2
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sleep_mode,
    input  logic                  uart_rx,
    output logic                  uart_wake,
    output logic [WAKE_CNT_W-1:0] wake_cnt,
    output logic                  busy
);

    localparam int unsigned TMR_W = cnt_width(CLKS_PER_BIT, HOLDOFF_CYCLES);

    // The shared timer counts down to zero, so each load is the interval minus one.
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(MIN_LOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

`ifdef UART_WAKE_BYTE_MATCH_EN
    localparam logic [TMR_W-1:0] BIT_LOAD   = TMR_W'(CLKS_PER_BIT - 1);
    // Qualification already consumed MIN_LOW_CYCLES of the start bit; the first
    // data sample lands at the centre of data bit 0.
    localparam logic [TMR_W-1:0] FIRST_LOAD = TMR_W'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - MIN_LOW_CYCLES - 1);
`else
    logic [7:0] unused_wake_byte;
    assign unused_wake_byte = WAKE_BYTE;
`endif

    logic             rx;
    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nx;
    logic             wake_nx;

`ifdef UART_WAKE_BYTE_MATCH_EN
    logic [7:0] shreg;
    logic [7:0] shreg_nx;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nx;
`endif

    pmu_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rx)
    );

    // Next-state, timer and wake-pulse decisions for the detector FSM.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        wake_nx  = 1'b0;
`ifdef UART_WAKE_BYTE_MATCH_EN
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
`endif
        case (state)
            ST_IDLE: begin
                // Requiring a high line here keeps a stuck-low line from ever waking.
                if (sleep_mode && rx) begin
                    state_nx = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!sleep_mode) begin
                    state_nx = ST_IDLE;
                end else if (!rx) begin
                    state_nx = ST_LOW_QUAL;
                    tmr_nx   = LOW_LOAD;
                end
            end
            ST_LOW_QUAL: begin
                // Timer at zero means MIN_LOW_CYCLES consecutive low samples have been seen.
                if (!sleep_mode) begin
                    state_nx = ST_IDLE;
                end else if (tmr == '0) begin
`ifdef UART_WAKE_BYTE_MATCH_EN
                    state_nx   = ST_DATA;
                    tmr_nx     = FIRST_LOAD;
                    bit_idx_nx = '0;
`else
                    state_nx = ST_HOLDOFF;
                    tmr_nx   = HOLD_LOAD;
                    wake_nx  = 1'b1;
`endif
                end else if (rx) begin
                    state_nx = ST_ARMED;
                end else begin
                    tmr_nx = tmr - TMR_ONE;
                end
            end
`ifdef UART_WAKE_BYTE_MATCH_EN
            ST_DATA: begin
                if (!sleep_mode) begin
                    state_nx = ST_IDLE;
                end else if (tmr == '0) begin
                    // LSB arrives first, so shift in from the top.
                    shreg_nx   = {rx, shreg[7:1]};
                    tmr_nx     = BIT_LOAD;
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = ST_STOP;
                    end
                end else begin
                    tmr_nx = tmr - TMR_ONE;
                end
            end
            ST_STOP: begin
                if (!sleep_mode) begin
                    state_nx = ST_IDLE;
                end else if (tmr == '0) begin
                    if (rx && (shreg == WAKE_BYTE)) begin
                        state_nx = ST_HOLDOFF;
                        tmr_nx   = HOLD_LOAD;
                        wake_nx  = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    tmr_nx = tmr - TMR_ONE;
                end
            end
`endif
            ST_HOLDOFF: begin
                // Deliberately blind to sleep_mode and rx until the window expires.
                if (tmr == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    tmr_nx = tmr - TMR_ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                tmr_nx   = '0;
            end
        endcase
    end

    // FSM state and shared timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

`ifdef UART_WAKE_BYTE_MATCH_EN
    // Received-byte shift register and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            shreg   <= shreg_nx;
            bit_idx <= bit_idx_nx;
        end
    end
`endif

    // Registered outputs: wake pulse, saturating wake counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_wake <= 1'b0;
            wake_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            uart_wake <= wake_nx;
            busy      <= is_busy(state_nx);
            if (wake_nx && (wake_cnt != '1)) begin
                wake_cnt <= wake_cnt + WAKE_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_wake_detector.sv
// Scoreboard bench for uart_wake_detector. Stimulus tasks compute, from the wake rules,
// the clock edge at which each pulse must appear and push it into a queue; a monitor on
// the falling edge pops and compares whenever uart_wake is seen high.
// Define UART_WAKE_BYTE_MATCH_EN for both bench and RTL to exercise the byte-match build.
module tb_uart_wake_detector;

    localparam int unsigned C  = 16;
    localparam int unsigned M  = 8;
    localparam int unsigned H  = 64;
    localparam int unsigned S  = 3;
    localparam logic [7:0]  WB = 8'h55;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       sleep_mode = 1'b0;
    logic       uart_rx    = 1'b1;
    logic       uart_wake;
    logic [7:0] wake_cnt;
    logic       busy;

    int unsigned cyc    = 0;
    int unsigned n_vec  = 0;
    int unsigned n_mis  = 0;
    int unsigned exp_cnt = 0;

    typedef struct {
        int unsigned at_edge;
        int unsigned cnt;
    } exp_t;

    exp_t sb[$];

    uart_wake_detector #(
        .CLKS_PER_BIT   (C),
        .MIN_LOW_CYCLES (M),
        .HOLDOFF_CYCLES (H),
        .WAKE_BYTE      (WB),
        .SYNC_STAGES    (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sleep_mode (sleep_mode),
        .uart_rx    (uart_rx),
        .uart_wake  (uart_wake),
        .wake_cnt   (wake_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Edge index: after the k-th rising edge, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && uart_wake) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_wake: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("wake_edge", cyc, mon_e.at_edge);
                check("wake_cnt_at_pulse", wake_cnt, mon_e.cnt);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int unsigned at_edge);
        exp_t e;
        exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        e.at_edge = at_edge;
        e.cnt     = exp_cnt;
        sb.push_back(e);
    endtask

    // Idle with the line high long enough for any holdoff to end and re-arm to happen.
    task automatic settle();
        tick(H + M + 2 * S + 20);
        check("pending_wakes", sb.size(), 0);
        check("busy_when_quiet", busy, 0);
        sb.delete();
    endtask

    // Hold the line low for L cycles; a wake is due iff the low run reaches M samples.
    task automatic ep_low(input int unsigned len);
        int unsigned t0;
        t0 = cyc + 1;
        uart_rx = 1'b0;
        if (len >= M) expect_pulse(t0 + S + M);
        tick(len);
        uart_rx = 1'b1;
        settle();
    endtask

    // Line goes low, then sleep_mode drops k edges later; a wake only if qualification came first.
    task automatic ep_sleep_drop(input int unsigned k);
        int unsigned t0;
        t0 = cyc + 1;
        uart_rx = 1'b0;
        if (k > S + M) expect_pulse(t0 + S + M);
        tick(k);
        sleep_mode = 1'b0;
        tick(1);
        if (k <= S + M) check("busy_after_sleep_drop", busy, 0);
        tick(5);
        uart_rx = 1'b1;
        tick(S + 2);
        sleep_mode = 1'b1;
        settle();
    endtask

`ifdef UART_WAKE_BYTE_MATCH_EN
    // One 8N1 frame; a wake is due at the stop-bit sample only for WB with a good stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        int unsigned t0;
        t0 = cyc + 1;
        if ((data == WB) && stop_bit) expect_pulse(t0 + S + 9 * C + C / 2);
        uart_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            tick(C);
        end
        uart_rx = stop_bit;
        tick(C);
        uart_rx = 1'b1;
        settle();
    endtask
`endif

    // Watchdog so the run can never hang.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time budget (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0;
        int unsigned e_edge;

        // Reset values
        tick(3);
        check("reset_uart_wake", uart_wake, 0);
        check("reset_wake_cnt", wake_cnt, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        sleep_mode = 1'b1;
        tick(S + 5);

`ifndef UART_WAKE_BYTE_MATCH_EN
        // Long low: one pulse, then busy for exactly H cycles starting with the pulse cycle
        t0 = cyc + 1;
        e_edge = t0 + S + M;
        uart_rx = 1'b0;
        expect_pulse(e_edge);
        while (cyc < e_edge + 1) @(negedge clk);
        check("wake_cnt_after_first", wake_cnt, 1);
        while (cyc < e_edge + H - 1) @(negedge clk);
        check("busy_last_holdoff_cycle", busy, 1);
        tick(1);
        check("busy_after_holdoff", busy, 0);
        tick(M + 20);
        uart_rx = 1'b1;
        settle();

        // Glitches around the qualification boundary
        ep_low(1);
        ep_low(M / 2);
        ep_low(M - 1);
        ep_low(M);
        ep_low(M + 1);

        // Randomised mix of low runs and sleep drops
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 0) ep_low($urandom_range(2 * M, 1));
            else ep_sleep_drop($urandom_range(S + M + 4, 1));
        end
        ep_sleep_drop(S + M);

        // Line already low when sleep starts: never wakes until it returns high
        sleep_mode = 1'b0;
        tick(2);
        uart_rx = 1'b0;
        tick(S + 3);
        sleep_mode = 1'b1;
        tick(2 * M + 30);
        check("no_wake_stuck_low", sb.size(), 0);
        uart_rx = 1'b1;
        tick(S + 3);
        ep_low(M + 3);

        // Second qualified low inside the holdoff window is ignored
        t0 = cyc + 1;
        uart_rx = 1'b0;
        expect_pulse(t0 + S + M);
        tick(M + 5);
        uart_rx = 1'b1;
        tick(20);
        uart_rx = 1'b0;
        tick(M + 5);
        uart_rx = 1'b1;
        settle();

        // Saturation of the wake counter
        for (int i = 0; i < 300; i++) ep_low(M + 1);
        check("wake_cnt_saturated", wake_cnt, 255);
`else
        // Frames: matching byte, near misses, bad stop bit, random bytes
        send_frame(WB, 1'b1);
        send_frame(8'h54, 1'b1);
        check("wake_cnt_after_mismatch", wake_cnt, 1);
        send_frame(WB, 1'b0);
        send_frame(8'hD5, 1'b1);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = ($urandom_range(1, 0) == 0) ? WB : 8'($urandom_range(255, 0));
            send_frame(b, 1'b1);
        end
        ep_sleep_drop(S + M + 3);
`endif

        // Reset in the middle of low qualification: outputs clear at once
        uart_rx = 1'b0;
        tick(S + M / 2);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_uart_wake", uart_wake, 0);
        check("midrun_reset_wake_cnt", wake_cnt, 0);
        check("midrun_reset_busy", busy, 0);
        uart_rx = 1'b1;
        exp_cnt = 0;
        sb.delete();
        tick(3);
        rst_n = 1'b1;
        tick(S + 3);
        check("wake_cnt_after_reset", wake_cnt, 0);
        ep_low(M + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
